// File: rtl/arb_matrix_state_if.sv
// Handshake bundle between the matrix-arbiter priority stage, its request source,
// the combinational grant stage and the grant consumer.
interface arb_matrix_state_if #(
  parameter int WIDTH = 4,
  parameter int IDXW  = $clog2(WIDTH)
);
  logic [WIDTH-1:0] v_req;
  logic [WIDTH-1:0] vv_matrix [WIDTH-1:0];
  logic [WIDTH-1:0] v_vld_s;
  logic [WIDTH-1:0] v_grant;
  logic             gnt_vld;
  logic             gnt_rdy;
  logic [WIDTH-1:0] gnt_onehot;
  logic [IDXW-1:0]  gnt_idx;
  logic [WIDTH-1:0] v_ack;
  logic             err;

  modport slave (
    input  v_req, v_grant, gnt_rdy,
    output vv_matrix, v_vld_s, gnt_vld, gnt_onehot, gnt_idx, v_ack, err
  );

  modport master (
    output v_req, v_grant, gnt_rdy,
    input  vv_matrix, v_vld_s, gnt_vld, gnt_onehot, gnt_idx, v_ack, err
  );
endinterface

// File: rtl/arb_matrix_state.sv
// Least-recently-granted priority matrix plus request snapshot / grant handshake
// stage that feeds and consumes the combinational matrix grant stage.
module arb_matrix_state #(
  parameter int WIDTH = 4,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  arb_matrix_state_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ARB, GNT} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] req_q_reg;
  logic [WIDTH-1:0] vld_s_reg;
  logic             gnt_vld_reg;
  logic [WIDTH-1:0] gnt_onehot_reg;
  logic [IDXW-1:0]  gnt_idx_reg;
  logic [WIDTH-1:0] ack_reg;
  logic             err_reg;
  logic [WIDTH-1:0] matrix_reg [WIDTH-1:0];

  logic [WIDTH-1:0] masked_next;
  logic [WIDTH-1:0] lowest_next;
  logic [IDXW-1:0]  idx_next;
  logic             multi_next;
  logic             stray_next;
  logic             handshake;

  // Only grant bits that were actually requested count; the rest flag an error.
  assign masked_next = bus.v_grant & req_q_reg;
  assign lowest_next = masked_next & (~masked_next + WIDTH'(1));
  assign multi_next  = |(masked_next & (masked_next - WIDTH'(1)));
  assign stray_next  = |(bus.v_grant & ~req_q_reg);
  assign handshake   = (state_reg == GNT) && gnt_vld_reg && bus.gnt_rdy;

  always_comb begin
    idx_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (lowest_next[i]) idx_next = IDXW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      req_q_reg      <= '0;
      vld_s_reg      <= '0;
      gnt_vld_reg    <= 1'b0;
      gnt_onehot_reg <= '0;
      gnt_idx_reg    <= '0;
      ack_reg        <= '0;
      err_reg        <= 1'b0;
    end else begin
      ack_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (|bus.v_req) begin
            req_q_reg <= bus.v_req;
            vld_s_reg <= bus.v_req;
            state_reg <= ARB;
          end
        end
        ARB: begin
          vld_s_reg <= '0;
          if (masked_next == '0) begin
            err_reg   <= 1'b1;
            state_reg <= IDLE;
          end else begin
            if (multi_next || stray_next) err_reg <= 1'b1;
            gnt_onehot_reg <= lowest_next;
            gnt_idx_reg    <= idx_next;
            gnt_vld_reg    <= 1'b1;
            state_reg      <= GNT;
          end
        end
        GNT: begin
          if (handshake) begin
            ack_reg     <= gnt_onehot_reg;
            gnt_vld_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Winner drops below everyone: clear its row, set its column in all other rows.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
      localparam logic [WIDTH-1:0] ROW_RST = {WIDTH{1'b1}} << (gi + 1);
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          matrix_reg[gi] <= ROW_RST;
        end else if (handshake) begin
          if (gnt_onehot_reg[gi]) matrix_reg[gi] <= '0;
          else                    matrix_reg[gi] <= matrix_reg[gi] | gnt_onehot_reg;
        end
      end
      assign bus.vv_matrix[gi] = matrix_reg[gi];
    end
  endgenerate

  assign bus.v_vld_s    = vld_s_reg;
  assign bus.gnt_vld    = gnt_vld_reg;
  assign bus.gnt_onehot = gnt_onehot_reg;
  assign bus.gnt_idx    = gnt_idx_reg;
  assign bus.v_ack      = ack_reg;
  assign bus.err        = err_reg;

endmodule

// File: tb/tb_arb_matrix_state.sv
// Directed + random bench for arb_matrix_state; the grant stage and an LRU-order
// reference model both live here.
module tb_arb_matrix_state;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arb_matrix_state_if #(.WIDTH(W)) bus ();
  arb_matrix_state #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Grant stage: i wins if it requests and beats every other requester.
  logic         force_en = 1'b0;
  logic [W-1:0] force_val = '0;
  logic [W-1:0] stage_gnt;
  always_comb begin
    stage_gnt = '0;
    for (int i = 0; i < W; i++) begin
      stage_gnt[i] = bus.v_vld_s[i];
      for (int j = 0; j < W; j++)
        if (j != i && bus.v_vld_s[j] && !bus.vv_matrix[i][j]) stage_gnt[i] = 1'b0;
    end
  end
  assign bus.v_grant = force_en ? force_val : stage_gnt;

  int n_checks = 0;
  int n_fail = 0;

  // Reference: queue of requesters, least recently granted first.
  int order[$];
  bit err_m;

  function automatic int pos(input int idx);
    for (int k = 0; k < order.size(); k++) if (order[k] == idx) return k;
    return -1;
  endfunction

  function automatic logic [W-1:0] exp_row(input int i);
    logic [W-1:0] r = '0;
    for (int j = 0; j < W; j++) r[j] = (i != j) && (pos(i) < pos(j));
    return r;
  endfunction

  task automatic model_reset();
    order = {0, 1, 2, 3};
    err_m = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_matrix(input string tag);
    for (int i = 0; i < W; i++) chk(tag, 32'(bus.vv_matrix[i]), 32'(exp_row(i)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full request/grant/handshake; widx returns the DUT's gnt_idx (or -1).
  task automatic txn(input logic [W-1:0] req, input int stall, input bit fen,
                     input logic [W-1:0] fval, output int widx);
    logic [W-1:0] masked;
    int w;
    w = -1;
    if (fen) begin
      masked = fval & req;
      for (int i = W - 1; i >= 0; i--) if (masked[i]) w = i;
      if (masked == '0 || $countones(masked) > 1 || (fval & ~req) != '0) err_m = 1'b1;
    end else begin
      for (int k = order.size() - 1; k >= 0; k--) if (req[order[k]]) w = order[k];
    end
    force_en = fen;
    force_val = fval;
    bus.v_req = req;
    bus.gnt_rdy = 1'b0;
    tick();
    chk("snapshot", 32'(bus.v_vld_s), 32'(req));
    chk("vld_in_arb", 32'(bus.gnt_vld), 0);
    bus.v_req = W'($urandom);
    tick();
    force_en = 1'b0;
    bus.v_req = '0;
    chk("gnt_vld", 32'(bus.gnt_vld), (w >= 0) ? 1 : 0);
    chk("err", 32'(bus.err), 32'(err_m));
    chk("ack_early", 32'(bus.v_ack), 0);
    chk_matrix("matrix_pre");
    widx = -1;
    if (w >= 0) begin
      widx = int'(bus.gnt_idx);
      chk("gnt_onehot", 32'(bus.gnt_onehot), 32'(1) << w);
      chk("gnt_idx", 32'(bus.gnt_idx), 32'(w));
      for (int s = 0; s < stall; s++) begin
        bus.v_req = W'($urandom);
        tick();
        chk("stall_vld", 32'(bus.gnt_vld), 1);
        chk("stall_onehot", 32'(bus.gnt_onehot), 32'(1) << w);
        chk("stall_ack", 32'(bus.v_ack), 0);
      end
      chk_matrix("matrix_stall");
      bus.v_req = '0;
      bus.gnt_rdy = 1'b1;
      tick();
      order.delete(pos(w));
      order.push_back(w);
      chk("ack", 32'(bus.v_ack), 32'(1) << w);
      chk("vld_drop", 32'(bus.gnt_vld), 0);
      chk_matrix("matrix_post");
      bus.gnt_rdy = 1'b0;
      tick();
      chk("ack_pulse", 32'(bus.v_ack), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    logic [W-1:0] r;
    logic [W-1:0] rst_rows [W];
    rst_rows = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    bus.v_req = '0;
    bus.gnt_rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < W; i++) chk("rst_row", 32'(bus.vv_matrix[i]), 32'(rst_rows[i]));
    chk("rst_vld", 32'(bus.gnt_vld), 0);
    chk("rst_oh", 32'(bus.gnt_onehot), 0);
    chk("rst_idx", 32'(bus.gnt_idx), 0);
    chk("rst_ack", 32'(bus.v_ack), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_vlds", 32'(bus.v_vld_s), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness from reset: 0,1,2,3 then back to reset matrix, then 0 again
    for (int k = 0; k < 5; k++) begin
      txn(4'b1111, 0, 1'b0, '0, w);
      chk("fair_order", 32'(w), 32'(k % 4));
      if (k == 3)
        for (int i = 0; i < W; i++) chk("fair_rst", 32'(bus.vv_matrix[i]), 32'(rst_rows[i]));
    end

    txn(4'b1010, 0, 1'b0, '0, w);
    txn(4'b1111, 5, 1'b0, '0, w);

    for (int k = 0; k < 30; k++) begin
      r = W'($urandom_range(1, 15));
      txn(r, $urandom_range(0, 3), 1'b0, '0, w);
    end

    // Grant-stage faults
    txn(4'b0101, 0, 1'b1, 4'b0000, w);
    chk("err_zero_nogrant", 32'(w), 32'hffff_ffff);
    txn(4'b0110, 1, 1'b1, 4'b0110, w);
    chk("err_multi_idx", 32'(w), 1);
    txn(4'b0001, 0, 1'b1, 4'b1001, w);

    // Asynchronous reset in the middle of a stalled grant
    bus.v_req = 4'b1111;
    tick();
    bus.v_req = '0;
    tick();
    chk("pre_rst_vld", 32'(bus.gnt_vld), 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < W; i++) chk("arst_row", 32'(bus.vv_matrix[i]), 32'(rst_rows[i]));
    chk("arst_vld", 32'(bus.gnt_vld), 0);
    chk("arst_oh", 32'(bus.gnt_onehot), 0);
    chk("arst_idx", 32'(bus.gnt_idx), 0);
    chk("arst_ack", 32'(bus.v_ack), 0);
    chk("arst_err", 32'(bus.err), 0);
    chk("arst_vlds", 32'(bus.v_vld_s), 0);
    @(negedge clk);
    rst_n = 1'b1;

    txn(4'b1010, 0, 1'b0, '0, w);
    chk("post_rst_idx", 32'(w), 1);
    chk("basic_row0", 32'(bus.vv_matrix[0]), 32'(4'b1110));
    chk("basic_row1", 32'(bus.vv_matrix[1]), 32'(4'b0000));
    chk("basic_row2", 32'(bus.vv_matrix[2]), 32'(4'b1010));
    chk("basic_row3", 32'(bus.vv_matrix[3]), 32'(4'b0010));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
